// File: rtl/kronos_mem_sched_pkg.sv
// kronos_mem_sched_pkg: shared widths and the in-flight record
// for the multi-requester SRAM scheduler.
package kronos_mem_sched_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int MASK_W = 4;
  localparam int IDX_W  = 3;

  typedef struct packed {
    logic             valid;
    logic             wr;
    logic [IDX_W-1:0] idx;
  } inflight_t;

endpackage

// File: rtl/kronos_mem_sched_if.sv
// kronos_mem_sched_if: requester bus plus SRAM port bundle.
// slave is the scheduler side, master the requesters/SRAM side.
interface kronos_mem_sched_if #(
  parameter int NUM_REQ = 4
);
  import kronos_mem_sched_pkg::*;

  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_wdata;
  logic [NUM_REQ*MASK_W-1:0] req_mask;
  logic [NUM_REQ-1:0]        req_wr_en;
  logic [NUM_REQ-1:0]        ack;
  logic [NUM_REQ*DATA_W-1:0] rdata;
  logic                      mem_en;
  logic                      mem_wr_en;
  logic [ADDR_W-1:0]         mem_addr;
  logic [DATA_W-1:0]         mem_wdata;
  logic [MASK_W-1:0]         mem_mask;
  logic [DATA_W-1:0]         mem_rdata;

  modport slave (
    input  req, req_addr, req_wdata,
    input  req_mask, req_wr_en, mem_rdata,
    output ack, rdata, mem_en, mem_wr_en,
    output mem_addr, mem_wdata, mem_mask
  );

  modport master (
    output req, req_addr, req_wdata,
    output req_mask, req_wr_en, mem_rdata,
    input  ack, rdata, mem_en, mem_wr_en,
    input  mem_addr, mem_wdata, mem_mask
  );

endinterface

// File: rtl/kronos_mem_sched_rr_pick.sv
// kronos_rr_pick: first set request bit at or after ptr,
// wrapping; one-hot grant plus valid.
module kronos_rr_pick #(
  parameter int NUM_REQ = 4,
  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PW-1:0]      ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic               vld
);

  logic          found;
  logic [PW-1:0] idx;

  // rotate from ptr and take the first hit
  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = PW'((int'(ptr) + k) % NUM_REQ);
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
    vld = |req;
  end

endmodule

// File: rtl/kronos_mem_sched.sv
// kronos_mem_sched: class round-robin with aging over one
// single-port SRAM; acks and read data return to the winner.
module kronos_mem_sched
  import kronos_mem_sched_pkg::*;
#(
  parameter int                 NUM_REQ  = 4,
  parameter logic [NUM_REQ-1:0] HI_MASK  = 4'b0011,
  parameter int                 MAX_WAIT = 7
) (
  input logic               clk,
  input logic               rstz,
  kronos_mem_sched_if.slave bus
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(MAX_WAIT + 1);

  logic [NUM_REQ-1:0] ack_q;
  logic [NUM_REQ-1:0] elig;
  logic [NUM_REQ-1:0] starved;
  logic [NUM_REQ-1:0] pick_in;
  logic [NUM_REQ-1:0] gnt;
  logic               pick_vld;
  logic               grant_v;
  logic [PW-1:0]      gidx;
  logic [PW-1:0]      ptr;
  logic [CW-1:0]      wcnt [NUM_REQ];
  inflight_t          infl;

  assign elig    = bus.req & ~ack_q;
  assign grant_v = pick_vld & rstz;
  assign bus.ack = ack_q;

  // starved set, then class priority picks the arbiter input
  always_comb begin
    starved = '0;
    for (int i = 0; i < NUM_REQ; i++)
      starved[i] = elig[i] && (wcnt[i] == CW'(MAX_WAIT));
    pick_in = elig;
    if (|starved)
      pick_in = starved;
    else if (|(elig & HI_MASK))
      pick_in = elig & HI_MASK;
  end

  kronos_rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_pick (
    .req (pick_in),
    .ptr (ptr),
    .gnt (gnt),
    .vld (pick_vld)
  );

  // one-hot grant to index
  always_comb begin
    gidx = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (gnt[i]) gidx = PW'(i);
  end

  // SRAM request from the granted port, zero when idle
  always_comb begin
    bus.mem_en    = grant_v;
    bus.mem_wr_en = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.mem_mask  = '0;
    if (grant_v) begin
      bus.mem_wr_en = bus.req_wr_en[gidx];
      bus.mem_addr  = bus.req_addr[gidx*ADDR_W +: ADDR_W];
      bus.mem_wdata = bus.req_wdata[gidx*DATA_W +: DATA_W];
      bus.mem_mask  = bus.req_mask[gidx*MASK_W +: MASK_W];
    end
  end

  // route SRAM read data to the acked reader only
  always_comb begin
    bus.rdata = '0;
    if (infl.valid && !infl.wr)
      bus.rdata[infl.idx*DATA_W +: DATA_W] = bus.mem_rdata;
  end

  // pointer, ack pulse and in-flight record
  always_ff @(posedge clk or negedge rstz) begin
    if (!rstz) begin
      ptr   <= '0;
      ack_q <= '0;
      infl  <= '0;
    end else begin
      ack_q      <= grant_v ? gnt : '0;
      infl.valid <= grant_v;
      infl.wr    <= grant_v & bus.req_wr_en[gidx];
      infl.idx   <= IDX_W'(gidx);
      if (grant_v)
        ptr <= PW'((int'(gidx) + 1) % NUM_REQ);
    end
  end

  // per-port aging counters, saturating at MAX_WAIT
  always_ff @(posedge clk or negedge rstz) begin
    if (!rstz) begin
      for (int i = 0; i < NUM_REQ; i++)
        wcnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!bus.req[i] || (grant_v && gnt[i]))
          wcnt[i] <= '0;
        else if (ack_q[i])
          wcnt[i] <= wcnt[i];
        else if (elig[i] && wcnt[i] != CW'(MAX_WAIT))
          wcnt[i] <= wcnt[i] + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_kronos_mem_sched.sv
// tb_kronos_mem_sched: directed stimulus with a scoreboard of
// expected acks, SRAM model, and an HI_MASK=0 fairness instance.
module tb_kronos_mem_sched;
  import kronos_mem_sched_pkg::*;

  logic clk  = 1'b0;
  logic rstz = 1'b0;
  always #5 clk = ~clk;

  kronos_mem_sched_if #(.NUM_REQ(4)) bus ();
  kronos_mem_sched_if #(.NUM_REQ(4)) bus_rr ();

  kronos_mem_sched #(
    .NUM_REQ  (4),
    .HI_MASK  (4'b0011),
    .MAX_WAIT (7)
  ) u_dut (
    .clk  (clk),
    .rstz (rstz),
    .bus  (bus.slave)
  );

  kronos_mem_sched #(
    .NUM_REQ  (4),
    .HI_MASK  (4'b0000),
    .MAX_WAIT (7)
  ) u_rr (
    .clk  (clk),
    .rstz (rstz),
    .bus  (bus_rr.slave)
  );

  typedef struct {
    int          idx;
    logic [31:0] data;
  } exp_t;

  exp_t sbq[$];
  int   errors = 0;
  int   checks = 0;

  bit [31:0] mem_w [0:255];
  bit        mem_v [0:255];

  function automatic logic [31:0] init_word(logic [31:0] a);
    if (a == 32'h100) return 32'hDEADBEEF;
    if (a == 32'h40)  return 32'h0;
    return 32'h1000_0000 | a;
  endfunction

  function automatic logic [31:0] rd_word(logic [31:0] a);
    logic [7:0] w;
    w = a[9:2];
    if (mem_v[w]) return mem_w[w];
    return init_word({a[31:2], 2'b00});
  endfunction

  function automatic logic [31:0] merge(logic [31:0] o,
                                        logic [31:0] n,
                                        logic [3:0]  m);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++)
      if (m[b]) r[b*8 +: 8] = n[b*8 +: 8];
    return r;
  endfunction

  // SRAM model, one-cycle read latency
  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_wr_en) begin
        mem_w[bus.mem_addr[9:2]] <= merge(rd_word(bus.mem_addr),
                                          bus.mem_wdata,
                                          bus.mem_mask);
        mem_v[bus.mem_addr[9:2]] <= 1'b1;
      end else begin
        bus.mem_rdata <= rd_word(bus.mem_addr);
      end
    end
  end

  exp_t        e;
  logic [127:0] exp_rd;

  // monitor: every ack pops one expected completion
  always @(negedge clk) begin
    if (rstz && bus.ack != 4'b0) begin
      checks++;
      if (sbq.size() == 0) begin
        errors++;
        $display("FAIL unexpected_ack ack=%b", bus.ack);
      end else begin
        e = sbq.pop_front();
        if (bus.ack !== 4'(1 << e.idx)) begin
          errors++;
          $display("FAIL ack_idx got=%b exp=%b",
                   bus.ack, 4'(1 << e.idx));
        end
        checks++;
        exp_rd = '0;
        exp_rd[e.idx*32 +: 32] = e.data;
        if (bus.rdata !== exp_rd) begin
          errors++;
          $display("FAIL rdata got=%h exp=%h",
                   bus.rdata, exp_rd);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string name, logic [63:0] act,
                     logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic push(int idx, logic [31:0] d);
    exp_t x;
    x.idx  = idx;
    x.data = d;
    sbq.push_back(x);
  endtask

  task automatic drain();
    for (int k = 0; k < 10 && sbq.size() != 0; k++)
      @(posedge clk);
    @(negedge clk);
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout got=%0d exp=0", sbq.size());
      sbq.delete();
    end
  endtask

  int seq2 [18] = '{0, 1, 0, 1, 0, 1, 0, 2, 3,
                    0, 1, 0, 1, 0, 1, 0, 2, 3};
  int cnt  [4];

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    int idx;
    bus.req       = '0;
    bus.req_wr_en = '0;
    bus.req_wdata = '0;
    bus.req_mask  = '1;
    bus_rr.req       = '0;
    bus_rr.req_wr_en = '0;
    bus_rr.req_wdata = '0;
    bus_rr.req_mask  = '1;
    bus_rr.mem_rdata = '0;
    for (int i = 0; i < 4; i++) begin
      bus.req_addr[i*32 +: 32]    = 32'h200 + 32'(4 * i);
      bus_rr.req_addr[i*32 +: 32] = 32'h200 + 32'(4 * i);
    end

    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ack", 64'(bus.ack), 0);
    chk("rst_rdata", 64'(bus.rdata[63:0]), 0);
    chk("rst_mem_en", 64'(bus.mem_en), 0);
    chk("rst_mem_wr", 64'(bus.mem_wr_en), 0);
    rstz = 1'b1;

    // single requester read, held req
    tick();
    bus.req_addr[2*32 +: 32] = 32'h100;
    bus.req[2] = 1'b1;
    @(negedge clk);
    chk("t1_mem_en", 64'(bus.mem_en), 1);
    chk("t1_addr", 64'(bus.mem_addr), 64'h100);
    chk("t1_wr", 64'(bus.mem_wr_en), 0);
    push(2, 32'hDEADBEEF);
    tick();
    @(negedge clk);
    chk("t1_no_regrant", 64'(bus.mem_en), 0);
    tick();
    @(negedge clk);
    chk("t1_regrant", 64'(bus.mem_en), 1);
    push(2, 32'hDEADBEEF);
    tick();
    bus.req[2] = 1'b0;
    drain();
    bus.req_addr[2*32 +: 32] = 32'h208;

    // class priority with aging promotion
    tick();
    bus.req = 4'hF;
    for (int c = 0; c < 18; c++) begin
      @(negedge clk);
      chk($sformatf("prio_grant%0d", c), 64'(bus.mem_addr),
          64'(32'h200 + 32'(4 * seq2[c])));
      push(seq2[c], 32'h1000_0200 + 32'(4 * seq2[c]));
      tick();
    end
    bus.req = '0;
    drain();

    // masked write then read-back
    tick();
    bus.req_addr[31:0]  = 32'h40;
    bus.req_wdata[31:0] = 32'hA5A5A5A5;
    bus.req_mask[3:0]   = 4'b0011;
    bus.req_wr_en[0]    = 1'b1;
    bus.req[0]          = 1'b1;
    @(negedge clk);
    chk("t3_wr_en", 64'(bus.mem_wr_en), 1);
    chk("t3_mask", 64'(bus.mem_mask), 64'h3);
    chk("t3_wdata", 64'(bus.mem_wdata), 64'hA5A5A5A5);
    push(0, 32'h0);
    tick();
    bus.req[0] = 1'b0;
    tick();
    bus.req_wr_en[0] = 1'b0;
    bus.req[0]       = 1'b1;
    @(negedge clk);
    chk("t3_rd_addr", 64'(bus.mem_addr), 64'h40);
    chk("t3_rd_wr", 64'(bus.mem_wr_en), 0);
    push(0, 32'h0000A5A5);
    tick();
    bus.req[0] = 1'b0;
    drain();
    bus.req_addr[31:0] = 32'h200;
    bus.req_mask[3:0]  = 4'hF;

    // reset during the ack cycle of a grant
    tick();
    bus.req = 4'b0001;
    @(negedge clk);
    chk("t4_grant", 64'(bus.mem_en), 1);
    tick();
    rstz     = 1'b0;
    bus.req  = 4'b0011;
    @(negedge clk);
    chk("t4_rst_ack", 64'(bus.ack), 0);
    chk("t4_rst_rdata", 64'(bus.rdata[63:0]), 0);
    chk("t4_rst_mem_en", 64'(bus.mem_en), 0);
    chk("t4_rst_mem_wr", 64'(bus.mem_wr_en), 0);
    @(negedge clk);
    chk("t4_rst_ack2", 64'(bus.ack), 0);
    rstz = 1'b1;
    #1;
    chk("t4_first_addr", 64'(bus.mem_addr), 64'h200);
    push(0, 32'h1000_0200);
    tick();
    bus.req[0] = 1'b0;
    @(negedge clk);
    chk("t4_second_addr", 64'(bus.mem_addr), 64'h204);
    push(1, 32'h1000_0204);
    tick();
    bus.req = '0;
    drain();

    // pure round-robin with HI_MASK = 0
    for (int i = 0; i < 4; i++) cnt[i] = 0;
    tick();
    bus_rr.req = 4'hF;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      idx = int'((bus_rr.mem_addr - 32'h200) >> 2);
      chk($sformatf("rr_order%0d", c), 64'(idx), 64'(c % 4));
      if (bus_rr.mem_en && idx >= 0 && idx < 4)
        cnt[idx]++;
      tick();
    end
    bus_rr.req = '0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (cnt[i] < 9 || cnt[i] > 11) begin
        errors++;
        $display("FAIL rr_count%0d got=%0d exp=10+-1", i, cnt[i]);
      end
    end

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/kronos_mem_sched.md
Name: kronos_mem_sched

Overview:
- Multi-requester scheduler for one single-port synchronous SRAM (generic_spram, 1-cycle read latency) shared by several kronos_core instruction/data ports.
- Replaces fixed-priority muxing with class-based round-robin plus an aging promotion so no port can starve.
- Routes acks and read data back to the granted requester.
- Sits between the cores' memory ports and the SRAM in multi-core tops.

Parameters:
- NUM_REQ, 4, number of requester ports (2..8); index order is core0 data, core1 data, core0 instr, core1 instr, ...
- HI_MASK, 4'b0011, bit i = 1 puts requester i in the high-priority class.
- MAX_WAIT, 7, number of cycles a pending request waits before it is promoted above both classes (1..255).

Ports:
- clk  in  1  clock
- rstz  in  1  reset; asynchronous, active-low
- req  in  NUM_REQ  request valid per requester; held until its ack
- req_addr  in  NUM_REQ*32  byte address, requester i at [32i+:32]
- req_wdata  in  NUM_REQ*32  write data
- req_mask  in  NUM_REQ*4  byte-enable mask
- req_wr_en  in  NUM_REQ  1 = write, 0 = read
- ack  out  NUM_REQ  one-cycle completion pulse per requester
- rdata  out  NUM_REQ*32  read data; valid only with ack of a read, otherwise 0
- mem_en  out  1  SRAM access enable
- mem_wr_en  out  1  SRAM write enable
- mem_addr  out  32  SRAM address
- mem_wdata  out  32  SRAM write data
- mem_mask  out  4  SRAM byte mask
- mem_rdata  in  32  SRAM read data, valid the cycle after a read enable

Behaviour:
- Reset (async, rstz low):
  - ack = 0, rdata = 0, mem_en = 0, mem_wr_en = 0.
  - RR pointer = 0, all wait counters = 0, in-flight register = NONE.
  - Reset mid-transaction discards the in-flight access; no ack is issued for it.
- Eligible set E = req & ~ack_q, where ack_q is the ack being driven this cycle. A requester is never regranted in its own ack cycle, so a held req cannot cause a duplicate access.
- Starved set S = E & (wait_cnt == MAX_WAIT).
- Selection, combinational, one grant per cycle:
  - If S is non-empty, pick from S; else if E & HI_MASK is non-empty, pick from that; else pick from E.
  - Within the chosen set, pick the first set bit at or after the RR pointer, wrapping modulo NUM_REQ.
- Grant cycle:
  - mem_en = 1; mem_addr, mem_wdata and mem_mask come from the granted requester.
  - mem_wr_en = req_wr_en of the granted requester.
  - With no grant, mem_en = 0 and all mem_* data outputs are 0.
- RR pointer: on a grant to g, pointer <= (g+1) mod NUM_REQ. Otherwise it holds.
- Wait counters, per requester i:
  - Reset to 0 when req[i] = 0 or when i is granted.
  - Increment, saturating at MAX_WAIT, when i is in E and not granted.
  - Hold during i's ack cycle.
  - Width is $clog2(MAX_WAIT+1).
- Completion, one cycle after the grant:
  - ack[g] = 1 for exactly one cycle, for both reads and writes.
  - For a read, rdata[g] = mem_rdata in that same cycle. All other rdata slices are 0.
- Throughput:
  - One access per cycle across all requesters.
  - A single requester gets at most one access every 2 cycles.
  - Worst-case latency for any request is bounded by MAX_WAIT + NUM_REQ cycles.
- Simultaneous events:
  - A new req raised in the same cycle another requester is acked competes normally.
  - If multiple requesters are starved at once, the RR pointer orders them.
- Requesters must not change addr, wdata, mask or wr_en while req is high and unacked. The scheduler samples only in the grant cycle.

Decomposition:
- Package kronos_mem_sched_pkg holds:
  - localparams for the address and data widths (32) and mask width (4);
  - the in-flight record typedef {valid, wr, idx}.
- Sub-module kronos_rr_pick (NUM_REQ): takes a request vector and a pointer, returns a one-hot grant and a valid bit. It is instantiated once and fed the set selected by class priority.

Test Plan:
- Single requester: req[2] read at 0x100 with the SRAM preloaded to 0xDEADBEEF -> mem_en in cycle 0, ack[2] and rdata[2] = 0xDEADBEEF in cycle 1, no regrant in cycle 1 while req is held, regrant in cycle 2.
- Class priority: req = 4'b1111 continuously with MAX_WAIT = 7 -> grants alternate 0, 1, 0, 1...; requester 2 is granted no later than its 8th waiting cycle, then requester 3 is promoted likewise.
- Round-robin fairness: HI_MASK = 0 and all four requesting for 40 cycles -> each requester receives 10 ± 1 grants, in order 0, 1, 2, 3.
- Write then read: req[0] writes 0xA5A5A5A5 with mask 4'b0011 to 0x40, then reads it back (prior content 0) -> write ack returns rdata[0] = 0; the read returns 0x0000A5A5.
- Reset mid-operation: rstz is pulled low in the cycle after a grant -> no ack, all outputs 0, pointer 0; after release, the first grant goes to the lowest-index requester of the top eligible class.
